// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one wait-state single-port memory between IF fetches and MEM loads/stores.
// Optional macro ARB_RR_EN selects round-robin tie-breaking instead of fixed MEM priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              ram_e,
  output logic              ram_rw,
  output logic              ram_se,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                if_ready_r;
  logic                mem_ready_r;
  logic [DATA_W-1:0]   if_data_r;
  logic [DATA_W-1:0]   mem_rdata_r;
  logic                ram_e_r;
  logic                ram_rw_r;
  logic                ram_se_r;
  logic [1:0]          ram_size_r;
  logic [ADDR_W-1:0]   ram_a_r;
  logic [DATA_W-1:0]   ram_di_r;
  logic                if_elig_s;
  logic                mem_elig_s;
  logic                tie_mem_s;
  logic                grant_if_s;
  logic                grant_mem_s;
  logic                done_s;

  // A requester whose ready pulse is showing this cycle is not eligible for a new grant.
  assign if_elig_s  = if_req & ~if_ready_r;
  assign mem_elig_s = mem_req & ~mem_ready_r;

`ifdef ARB_RR_EN
  logic last_mem_r;

  // Round-robin history: remembers which requester was granted most recently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_mem_r <= 1'b1;
    end else if (grant_mem_s) begin
      last_mem_r <= 1'b1;
    end else if (grant_if_s) begin
      last_mem_r <= 1'b0;
    end else begin
      last_mem_r <= last_mem_r;
    end
  end

  assign tie_mem_s = ~last_mem_r;
`else
  assign tie_mem_s = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_mem_s) begin
          state_nxt_s = BUSY_MEM;
        end else if (grant_if_s) begin
          state_nxt_s = BUSY_IF;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: grant selection in IDLE and access completion in BUSY states.
  always_comb begin
    grant_if_s  = 1'b0;
    grant_mem_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_elig_s && mem_elig_s) begin
          grant_mem_s = tie_mem_s;
          grant_if_s  = ~tie_mem_s;
        end else if (mem_elig_s) begin
          grant_mem_s = 1'b1;
        end else if (if_elig_s) begin
          grant_if_s = 1'b1;
        end else begin
          grant_if_s  = 1'b0;
          grant_mem_s = 1'b0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        done_s = (cnt_r == CNT_ZERO);
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Wait-state counter: loaded at grant, counts down to zero during the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= CNT_ZERO;
    end else if (grant_if_s || grant_mem_s) begin
      cnt_r <= CNT_LOAD;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Memory command latched at grant; held stable for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_e_r    <= 1'b0;
      ram_rw_r   <= 1'b0;
      ram_se_r   <= 1'b0;
      ram_size_r <= 2'b00;
      ram_a_r    <= {ADDR_W{1'b0}};
      ram_di_r   <= {DATA_W{1'b0}};
    end else if (grant_mem_s) begin
      ram_e_r    <= 1'b1;
      ram_rw_r   <= mem_rw;
      ram_se_r   <= mem_se;
      ram_size_r <= mem_size;
      ram_a_r    <= mem_addr;
      ram_di_r   <= mem_wdata;
    end else if (grant_if_s) begin
      ram_e_r    <= 1'b1;
      ram_rw_r   <= 1'b0;
      ram_se_r   <= 1'b0;
      ram_size_r <= 2'b10;
      ram_a_r    <= if_addr;
      ram_di_r   <= ram_di_r;
    end else if (done_s) begin
      ram_e_r    <= 1'b0;
    end else begin
      ram_e_r    <= ram_e_r;
    end
  end

  // Completion: one-cycle ready pulses and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      if_data_r   <= {DATA_W{1'b0}};
      mem_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if_ready_r  <= done_s && (state_r == BUSY_IF);
      mem_ready_r <= done_s && (state_r == BUSY_MEM);
      if (done_s && (state_r == BUSY_IF)) begin
        if_data_r <= ram_do;
      end else begin
        if_data_r <= if_data_r;
      end
      // Stores complete with a ready pulse but leave the load result untouched.
      if (done_s && (state_r == BUSY_MEM) && !ram_rw_r) begin
        mem_rdata_r <= ram_do;
      end else begin
        mem_rdata_r <= mem_rdata_r;
      end
    end
  end

  assign if_ready  = if_ready_r;
  assign if_data   = if_data_r;
  assign if_stall  = if_req & ~if_ready_r;
  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;
  assign mem_stall = mem_req & ~mem_ready_r;
  assign ram_e     = ram_e_r;
  assign ram_rw    = ram_rw_r;
  assign ram_se    = ram_se_r;
  assign ram_size  = ram_size_r;
  assign ram_a     = ram_a_r;
  assign ram_di    = ram_di_r;
  assign busy      = ram_e_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Honours ARB_RR_EN in the model when the macro is defined for the build.
module tb_mem_port_arbiter;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LAT = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, mem_req, mem_rw, mem_se;
  logic [AW-1:0] if_addr, mem_addr;
  logic [1:0]    mem_size;
  logic [DW-1:0] mem_wdata;
  logic          if_ready, if_stall, mem_ready, mem_stall;
  logic [DW-1:0] if_data, mem_rdata;
  logic          ram_e, ram_rw, ram_se, busy;
  logic [1:0]    ram_size;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_do;

  logic [DW-1:0] ram_arr   [0:511];
  logic [DW-1:0] model_mem [0:511];

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction model: owner (0 none, 1 IF, 2 MEM), edge at which the access finishes.
  int            edge_n = 0;
  int            m_own, m_fin;
  logic          m_if_rdy, m_mem_rdy, m_last_mem;
  logic [DW-1:0] m_if_data, m_mem_rdata;
  logic [AW-1:0] m_a;
  logic          m_rw, m_se;
  logic [1:0]    m_size;
  logic [DW-1:0] m_di;
  logic          pw_v;
  logic [AW-1:0] pw_a;
  logic [DW-1:0] pw_d;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data), .if_stall(if_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ram_e(ram_e), .ram_rw(ram_rw), .ram_se(ram_se), .ram_size(ram_size), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do), .busy(busy)
  );

  always #5 clk = ~clk;

  assign ram_do = ram_arr[ram_a];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_fin = 0;
    m_if_rdy = 1'b0; m_mem_rdy = 1'b0; m_last_mem = 1'b1;
    m_if_data = '0; m_mem_rdata = '0;
    m_a = '0; m_rw = 1'b0; m_se = 1'b0; m_size = 2'b00; m_di = '0;
    pw_v = 1'b0;
  endtask

  // One rising edge of the reference: either finish the current access or arbitrate.
  task automatic model_step();
    logic nif, nmem, ie, me;
    edge_n++;
    nif = 1'b0; nmem = 1'b0;
    if (m_own != 0) begin
      if (edge_n == m_fin) begin
        if (m_own == 1) begin
          m_if_data = model_mem[m_a];
          nif = 1'b1;
        end else begin
          if (m_rw) model_mem[m_a] = m_di;
          else      m_mem_rdata = model_mem[m_a];
          nmem = 1'b1;
        end
        m_own = 0;
      end
    end else begin
      ie = if_req && !m_if_rdy;
      me = mem_req && !m_mem_rdy;
      if (me && (!ie || !RR || !m_last_mem)) begin
        m_own = 2; m_a = mem_addr; m_rw = mem_rw; m_se = mem_se; m_size = mem_size; m_di = mem_wdata;
        m_last_mem = 1'b1;
        m_fin = edge_n + LAT;
      end else if (ie) begin
        m_own = 1; m_a = if_addr; m_rw = 1'b0; m_se = 1'b0; m_size = 2'b10;
        m_last_mem = 1'b0;
        m_fin = edge_n + LAT;
      end
    end
    m_if_rdy = nif;
    m_mem_rdy = nmem;
  endtask

  task automatic check_outputs();
    chk("if_ready", if_ready, m_if_rdy);
    chk("mem_ready", mem_ready, m_mem_rdy);
    chk("if_data", if_data, m_if_data);
    chk("mem_rdata", mem_rdata, m_mem_rdata);
    chk("if_stall", if_stall, if_req & ~m_if_rdy);
    chk("mem_stall", mem_stall, mem_req & ~m_mem_rdy);
    chk("ram_e", ram_e, m_own != 0);
    chk("busy", busy, m_own != 0);
    if (m_own != 0) begin
      chk("ram_a", ram_a, m_a);
      chk("ram_rw", ram_rw, m_rw);
      chk("ram_size", ram_size, m_size);
      chk("ram_se", ram_se, m_se);
      if (m_rw) chk("ram_di", ram_di, m_di);
    end
  endtask

  // Memory device: a write is committed on the edge that ends a cycle with ram_e & ram_rw.
  task automatic cycle();
    @(posedge clk);
    if (pw_v) ram_arr[pw_a] = pw_d;
    pw_v = 1'b0;
    if (reset) model_step();
    @(negedge clk);
    check_outputs();
    if (ram_e && ram_rw) begin
      pw_v = 1'b1; pw_a = ram_a; pw_d = ram_di;
    end
  endtask

  task automatic new_mem_cmd();
    mem_req   = 1'b1;
    mem_addr  = AW'($urandom_range(0, 31));
    mem_rw    = 1'($urandom_range(0, 1));
    mem_size  = 2'($urandom_range(0, 2));
    mem_se    = 1'($urandom_range(0, 1));
    mem_wdata = $urandom;
  endtask

  // Requesters hold until ready, then drop or re-issue on the edge ending the ready cycle.
  task automatic drive_random();
    if (if_req && m_if_rdy) begin
      if ($urandom_range(0, 1) == 1) if_addr = AW'($urandom_range(0, 31));
      else if_req = 1'b0;
    end else if (!if_req && $urandom_range(0, 2) != 0) begin
      if_req = 1'b1;
      if_addr = AW'($urandom_range(0, 31));
    end
    if (mem_req && m_mem_rdy) begin
      if ($urandom_range(0, 1) == 1) new_mem_cmd();
      else mem_req = 1'b0;
    end else if (!mem_req && $urandom_range(0, 2) != 0) begin
      new_mem_cmd();
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] init16;
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_addr = '0; mem_rw = 1'b0; mem_size = 2'b00; mem_se = 1'b0; mem_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      ram_arr[i]   = (i * 32'h9E3779B9) ^ 32'h8C220004;
      model_mem[i] = (i * 32'h9E3779B9) ^ 32'h8C220004;
    end
    init16 = ram_arr[16];
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_di", ram_di, 0);
    chk("rst_ram_size", ram_size, 0);
    reset = 1'b1;

    // Reset during a store must abort it with nothing written.
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 9'h010; mem_wdata = 32'hDEADBEEF;
    mem_size = 2'b10; mem_se = 1'b0;
    cycle();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_ram_e", ram_e, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_mem_ready", mem_ready, 1'b0);
    chk("async_ram_a", ram_a, 0);
    chk("async_ram_di", ram_di, 0);
    cycle();
    chk("no_partial_write", ram_arr[16], init16);
    reset = 1'b1;
    n = 0;
    while (!m_mem_rdy && n < 20) begin
      cycle();
      n++;
    end
    chk("retry_ready", mem_ready, 1'b1);
    chk("retry_write", ram_arr[16], 32'hDEADBEEF);
    mem_req = 1'b0;
    cycle();

    // Lone fetch: ready arrives LATENCY edges after the grant edge.
    ram_arr[4] = 32'h8C220004;
    model_mem[4] = 32'h8C220004;
    if_req = 1'b1; if_addr = 9'h004;
    n = 0;
    while (!m_if_rdy && n < 20) begin
      cycle();
      n++;
    end
    chk("fetch_lat", n, LAT + 1);
    chk("fetch_ready", if_ready, 1'b1);
    chk("fetch_data", if_data, 32'h8C220004);
    if_req = 1'b0;
    cycle();

    // Both requesters held continuously: exercises the tie-break rule.
    if_req = 1'b1; if_addr = 9'h008;
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 9'h00C; mem_size = 2'b10;
    for (int i = 0; i < 4 * (LAT + 2); i++) cycle();
    if_req = 1'b0; mem_req = 1'b0;
    while (m_own != 0 || m_if_rdy || m_mem_rdy) cycle();
    cycle();

    for (int i = 0; i < 3000; i++) begin
      cycle();
      drive_random();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
